// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and op-class decode for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] ADD = 5'b00001;
    localparam logic [4:0] SUB = 5'b10001;
    localparam logic [4:0] SLL = 5'b00010;
    localparam logic [4:0] SRL = 5'b01010;
    localparam logic [4:0] SRA = 5'b01110;
    localparam logic [4:0] AND = 5'b00000;
    localparam logic [4:0] OR  = 5'b00100;
    localparam logic [4:0] XOR = 5'b01000;
    localparam logic [4:0] NOR = 5'b01100;
    localparam logic [4:0] LT  = 5'b10011;
    localparam logic [4:0] LTU = 5'b10111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef enum logic [2:0] {CLS_BOOL, CLS_ARITH, CLS_SHIFT, CLS_CMP, CLS_ILLEGAL} op_class_t;

    function automatic op_class_t op_class(input logic [4:0] fn);
        op_class_t cls;
        case (fn[1:0])
            2'b00:   cls = CLS_BOOL;
            2'b01:   cls = CLS_ARITH;
            2'b10:   cls = CLS_SHIFT;
            default: cls = fn[4] ? CLS_CMP : CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_flags_calc.sv
// Single-cycle result and N/Z/C/V generation for add/sub, boolean and compare ops.
module alu_flags_calc
    import alu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic [4:0]       fn_i,
    output logic [width-1:0] r_o,
    output logic             n_o,
    output logic             z_o,
    output logic             c_o,
    output logic             v_o
);

    logic [width-1:0] b_eff;
    logic [width:0]   sum;
    logic             ovf;
    logic             lt_s;
    logic             lt_u;

    always_comb begin
        // Subtract and compare share the A + ~B + 1 adder path.
        b_eff = fn_i[4] ? ~b_i : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff} + {{width{1'b0}}, fn_i[4]};
        ovf   = (a_i[width-1] == b_eff[width-1]) && (sum[width-1] != a_i[width-1]);
        lt_s  = sum[width-1] ^ ovf;
        lt_u  = ~sum[width];

        r_o = '0;
        c_o = 1'b0;
        v_o = 1'b0;
        case (op_class(fn_i))
            CLS_ARITH: begin
                r_o = sum[width-1:0];
                c_o = sum[width];
                v_o = ovf;
            end
            CLS_BOOL: begin
                case (fn_i[3:2])
                    2'b00:   r_o = a_i & b_i;
                    2'b01:   r_o = a_i | b_i;
                    2'b10:   r_o = a_i ^ b_i;
                    default: r_o = ~(a_i | b_i);
                endcase
            end
            CLS_CMP: begin
                r_o = {{(width-1){1'b0}}, (fn_i[2] ? lt_u : lt_s)};
                c_o = sum[width];
                v_o = ovf;
            end
            default: ;
        endcase
        n_o = r_o[width-1];
        z_o = (r_o == '0);
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU responder: one-cycle arithmetic/logic ops, shifts run one bit per clock.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic [4:0]       ALUfn,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [width-1:0] R,
    output logic             FlagN,
    output logic             FlagZ,
    output logic             FlagC,
    output logic             FlagV
);

    localparam int SW = $clog2(width);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with rsp_valid && rsp_ready.

    state_t           state_q, state_d;
    logic             right_q, right_d;
    logic             arith_q, arith_d;
    logic [width-1:0] sh_q, sh_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] r_q, r_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic [width-1:0] calc_r;
    logic             calc_n, calc_z, calc_c, calc_v;
    logic [width-1:0] sh_next;
    logic [SW-1:0]    amt;

    alu_flags_calc #(.width(width)) u_calc (
        .a_i  (A),
        .b_i  (B),
        .fn_i (ALUfn),
        .r_o  (calc_r),
        .n_o  (calc_n),
        .z_o  (calc_z),
        .c_o  (calc_c),
        .v_o  (calc_v)
    );

    assign amt     = A[SW-1:0];
    assign sh_next = right_q ? {arith_q & sh_q[width-1], sh_q[width-1:1]}
                             : {sh_q[width-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        right_d = right_q;
        arith_d = arith_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (op_class(ALUfn) == CLS_SHIFT) begin
                        right_d = ALUfn[3];
                        arith_d = ALUfn[2];
                        if (amt == '0) begin
                            r_d     = B;
                            n_d     = B[width-1];
                            z_d     = (B == '0);
                            c_d     = 1'b0;
                            v_d     = 1'b0;
                            state_d = DONE;
                        end else begin
                            sh_d    = B;
                            cnt_d   = amt;
                            state_d = SHIFT;
                        end
                    end else begin
                        r_d     = calc_r;
                        n_d     = calc_n;
                        z_d     = calc_z;
                        c_d     = calc_c;
                        v_d     = calc_v;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SW'(1)) begin
                    r_d     = sh_next;
                    n_d     = sh_next[width-1];
                    z_d     = (sh_next == '0);
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            right_q <= 1'b0;
            arith_q <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            right_q <= right_d;
            arith_q <= arith_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign R         = r_q;
    assign FlagN     = n_q;
    assign FlagZ     = z_q;
    assign FlagC     = c_q;
    assign FlagV     = v_q;

endmodule
